// File: rtl/tone_nco_pkg.sv
// Shared types and constants for the tone_nco multi-channel oscillator.
// Optional build feature: TONE_NCO_DUTY_EN (per-channel square duty threshold).
package tone_nco_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_SQUARE = 2'b01,
        MODE_SAW    = 2'b10,
        MODE_TRI    = 2'b11
    } mode_e;

    localparam int OUT_W_DEF = 8;

    // Largest positive two's-complement value of a given width; square levels use +/- this.
    function automatic int out_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    localparam int OUT_MAX = out_max(OUT_W_DEF);

    // Channel-select width, never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tone_nco_wave.sv
// Combinational waveform shaper: top phase bits + mode (+ duty) -> signed sample.
// With TONE_NCO_DUTY_EN the square is high while p < duty, otherwise while phase MSB is 0.
module tone_nco_wave
    import tone_nco_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W:0]   phase_top,
    input  logic [1:0]       mode,
`ifdef TONE_NCO_DUTY_EN
    input  logic [OUT_W-1:0] duty,
`endif
    output logic [OUT_W-1:0] wave
);

    localparam logic [OUT_W-1:0] SQ_POS = OUT_W'(out_max(OUT_W));
    localparam logic [OUT_W-1:0] SQ_NEG = OUT_W'(-out_max(OUT_W));

    logic             msb;
    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] tri_fold;
    logic             high;

    // phase_top holds phase[MSB -: OUT_W+1]: p is its upper OUT_W bits, q its lower OUT_W bits.
    assign msb      = phase_top[OUT_W];
    assign p        = phase_top[OUT_W:1];
    assign q        = phase_top[OUT_W-1:0];
    assign tri_fold = msb ? ~q : q;

`ifdef TONE_NCO_DUTY_EN
    assign high = (p < duty);
`else
    assign high = ~msb;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wave = '0;
        unique case (mode_e'(mode))
            MODE_OFF:    wave = '0;
            MODE_SQUARE: wave = high ? SQ_POS : SQ_NEG;
            MODE_SAW:    wave = {~p[OUT_W-1], p[OUT_W-2:0]};
            MODE_TRI:    wave = {~tri_fold[OUT_W-1], tri_fold[OUT_W-2:0]};
        endcase
    end

endmodule

// File: rtl/tone_nco.sv
// Multi-channel NCO: sample-rate divider, per-channel phase accumulators, config registers and mixer.
// Optional build feature: TONE_NCO_DUTY_EN adds a per-channel square duty register.
module tone_nco
    import tone_nco_pkg::*;
#(
    parameter  int PHASE_W    = 24,
    parameter  int OUT_W      = 8,
    parameter  int NUM_CH     = 4,
    parameter  int SAMPLE_DIV = 1042,
    localparam int MIX_W      = OUT_W + $clog2(NUM_CH),
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [1:0]         cfg_mode,
    input  logic [OUT_W-1:0]   cfg_duty,
    input  logic               cfg_phase_clr,
    output logic               sample_valid,
    output logic [MIX_W-1:0]   mix_out,
    output logic [NUM_CH-1:0]  tone_bits
);

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               tick_d;

    logic [PHASE_W-1:0] phase_q    [NUM_CH];
    logic [PHASE_W-1:0] phase_next [NUM_CH];
    logic [PHASE_W-1:0] inc_q      [NUM_CH];
    mode_e              mode_q     [NUM_CH];
    logic [OUT_W-1:0]   wave       [NUM_CH];
    logic [NUM_CH-1:0]  wr_sel;
    logic [NUM_CH-1:0]  tone_next;

    logic signed [MIX_W-1:0] mix_sum;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            tick_d  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            tick_d  <= tick;
        end
    end

    // Out-of-range channel numbers match no entry, so such writes fall away.
    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_sel[c] = cfg_we && (cfg_ch == CH_W'(c));
        end
    end

    // A clear beats accumulation on the same edge; accumulation always uses the pre-write inc.
    always_comb begin
        tone_next = tone_bits;
        for (int c = 0; c < NUM_CH; c++) begin
            phase_next[c] = phase_q[c];
            if (wr_sel[c] && cfg_phase_clr) begin
                phase_next[c] = '0;
            end else if (tick) begin
                phase_next[c] = phase_q[c] + inc_q[c];
            end
            if (tick) begin
                tone_next[c] = phase_next[c][PHASE_W-1];
            end
        end
    end

    // NOTE: the per-channel register file is small and must start silent, so every entry is reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                phase_q[c] <= '0;
                inc_q[c]   <= '0;
                mode_q[c]  <= MODE_OFF;
            end
            tone_bits <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                phase_q[c] <= phase_next[c];
                if (wr_sel[c]) begin
                    inc_q[c]  <= cfg_inc;
                    mode_q[c] <= mode_e'(cfg_mode);
                end
            end
            tone_bits <= tone_next;
        end
    end

`ifdef TONE_NCO_DUTY_EN
    localparam logic [OUT_W-1:0] DUTY_RST = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] duty_q [NUM_CH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                duty_q[c] <= DUTY_RST;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_sel[c]) begin
                    duty_q[c] <= cfg_duty;
                end
            end
        end
    end
`else
    logic unused_duty;
    assign unused_duty = ^cfg_duty;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_nco_wave #(
            .OUT_W     (OUT_W)
        ) u_wave (
            .phase_top (phase_q[c][PHASE_W-1 -: OUT_W+1]),
            .mode      (mode_q[c]),
`ifdef TONE_NCO_DUTY_EN
            .duty      (duty_q[c]),
`endif
            .wave      (wave[c])
        );
    end

    // MIX_W carries log2(NUM_CH) guard bits, so the plain sum cannot overflow.
    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mix_sum = mix_sum + MIX_W'($signed(wave[c]));
        end
    end

    // Mixing one edge after the tick sees the freshly advanced phases and any mode written at the tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            mix_out      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick_d;
            if (tick_d) begin
                mix_out <= mix_sum;
            end
        end
    end

endmodule
